conv_interleaver: RTL

Parametrised convolutional (Forney) interleaver/deinterleaver for the channel-coding chain. A commutator distributes valid input samples round-robin over BRANCHES branches. Each branch is a delay line whose length depends on the branch index and the mode. The same RTL is instantiated after the encoder (interleave) and before the decoder (deinterleave), so that the pair restores the original sample order.

---
 rtl/conv_il_pkg.sv | 20 ++
 rtl/conv_il_branch.sv | 33 +++
 rtl/conv_interleaver.sv | 78 +++++++
 3 files changed

// File: rtl/conv_il_pkg.sv
// Shared types and helpers for the convolutional interleaver/deinterleaver.
package conv_il_pkg;

  typedef enum logic {
    IL_INTERLEAVE   = 1'b0,
    IL_DEINTERLEAVE = 1'b1
  } il_mode_t;

  // Delay of branch b in branch-samples; the two modes are mirror images
  function automatic int unsigned branch_len(int unsigned b, int unsigned branches,
                                             int unsigned cell_depth, il_mode_t mode);
    if (mode == IL_INTERLEAVE) return b * cell_depth;
    return (branches - 1 - b) * cell_depth;
  endfunction

  function automatic int unsigned br_width(int unsigned branches);
    return (branches < 2) ? 1 : $clog2(branches);
  endfunction

endpackage

// File: rtl/conv_il_branch.sv
// One commutator branch: a LEN-cell shift register, or a plain wire when LEN is 0.
module conv_il_branch #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned LEN    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  if (LEN == 0) begin : g_wire
    logic unused;
    assign unused = ^{i_clk, i_rst_n, i_en};
    assign o_data = i_data;
  end else begin : g_shift
    logic [DATA_W-1:0] cells [LEN];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int k = 0; k < int'(LEN); k++) cells[k] <= '0;
      end else if (i_en) begin
        cells[0] <= i_data;
        for (int k = 1; k < int'(LEN); k++) cells[k] <= cells[k-1];
      end
    end

    // Oldest cell, read before this edge's shift
    assign o_data = cells[LEN-1];
  end

endmodule

// File: rtl/conv_interleaver.sv
// Convolutional (Forney) interleaver/deinterleaver with a registered output.
// Optional CONV_IL_SYNC_EN adds i_sync to force a sample onto branch 0.
module conv_interleaver
  import conv_il_pkg::*;
#(
  parameter int unsigned DATA_W     = 1,
  parameter int unsigned BRANCHES   = 7,
  parameter int unsigned CELL_DEPTH = 1,
  parameter il_mode_t    MODE       = IL_INTERLEAVE
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_dv,
`ifdef CONV_IL_SYNC_EN
  input  logic                          i_sync,
`endif
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_dv,
  output logic [br_width(BRANCHES)-1:0] o_branch
);

  localparam int unsigned BR_W = br_width(BRANCHES);

  if (BRANCHES < 2) begin : g_chk_branches
    $error("conv_interleaver: BRANCHES must be >= 2");
  end
  if (CELL_DEPTH < 1) begin : g_chk_depth
    $error("conv_interleaver: CELL_DEPTH must be >= 1");
  end

  logic [BR_W-1:0]   br;
  logic [BR_W-1:0]   br_nxt;
  logic [BR_W-1:0]   sel;
  logic [DATA_W-1:0] mux_data;
  logic [DATA_W-1:0] branch_out [BRANCHES];

  // Commutator select, next position and output mux
  always_comb begin
    sel = br;
`ifdef CONV_IL_SYNC_EN
    if (i_sync) sel = '0;
`endif
    br_nxt = br;
    if (i_dv) br_nxt = (sel == BR_W'(BRANCHES - 1)) ? '0 : sel + BR_W'(1);
    mux_data = branch_out[sel];
  end

  for (genvar b = 0; b < int'(BRANCHES); b++) begin : g_branch
    conv_il_branch #(
      .DATA_W (DATA_W),
      .LEN    (branch_len(b, BRANCHES, CELL_DEPTH, MODE))
    ) u_branch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_dv && (sel == BR_W'(b))),
      .i_data  (i_data),
      .o_data  (branch_out[b])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br       <= '0;
      o_data   <= '0;
      o_dv     <= 1'b0;
      o_branch <= '0;
    end else begin
      br   <= br_nxt;
      o_dv <= i_dv;
      if (i_dv) begin
        o_data   <= mux_data;
        o_branch <= sel;
      end
    end
  end

endmodule
